// File: rtl/color_write_sequencer.sv
// Serialises a 24-bit colour write into six 4-bit register-file writes,
// one nibble per ack handshake, with idle gaps between writes and an ack timeout.
module color_write_sequencer #(
    parameter int ACK_TIMEOUT = 255,
    parameter int GAP_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_channel,
    input  logic [23:0] req_rgb,
    output logic [1:0]  channel,
    output logic [3:0]  address,
    output logic [3:0]  data,
    output logic        valid,
    input  logic        ack,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_GAP,
        S_FINISH,
        S_ABORT
    } state_t;

    localparam logic [9:0] TO_LAST  = 10'(ACK_TIMEOUT - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t      state, state_nxt;
    logic [1:0]  cap_ch;
    logic [23:0] cap_rgb;
    logic [2:0]  idx;
    logic [9:0]  to_cnt;
    logic [3:0]  gap_cnt;

    logic        nib_last, to_hit, gap_end, drive_entry, gap_entry;
    logic [1:0]  src_ch;
    logic [23:0] src_rgb;
    logic [2:0]  src_idx;

    function automatic logic [3:0] nib_sel(input logic [23:0] rgb, input logic [2:0] i);
        case (i)
            3'd0:    nib_sel = rgb[3:0];
            3'd1:    nib_sel = rgb[7:4];
            3'd2:    nib_sel = rgb[11:8];
            3'd3:    nib_sel = rgb[15:12];
            3'd4:    nib_sel = rgb[19:16];
            default: nib_sel = rgb[23:20];
        endcase
    endfunction

    assign nib_last = (idx == 3'd5);
    // The counter holds completed wait cycles, so hitting the last value with
    // no ack means this is the ACK_TIMEOUT-th DRIVE cycle.
    assign to_hit   = (to_cnt == TO_LAST);
    assign gap_end  = (gap_cnt == GAP_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (req_valid) state_nxt = S_DRIVE;
            S_DRIVE: begin
                if (ack)         state_nxt = nib_last ? S_FINISH : S_GAP;
                else if (to_hit) state_nxt = S_ABORT;
            end
            S_GAP:    if (gap_end) state_nxt = S_DRIVE;
            S_FINISH: state_nxt = S_IDLE;
            S_ABORT:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign req_ready = (state == S_IDLE);
    assign busy      = ~req_ready;
    assign valid     = (state == S_DRIVE);
    assign done      = (state == S_FINISH);
    assign err       = (state == S_ABORT);

    assign drive_entry = (state_nxt == S_DRIVE) && (state != S_DRIVE);
    assign gap_entry   = (state_nxt == S_GAP) && (state != S_GAP);

    // On the accept edge the captured copies are not yet loaded; drive from the request.
    assign src_ch  = (state == S_IDLE) ? req_channel : cap_ch;
    assign src_rgb = (state == S_IDLE) ? req_rgb : cap_rgb;
    assign src_idx = (state == S_IDLE) ? 3'd0 : idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cap_ch  <= '0;
            cap_rgb <= '0;
            idx     <= '0;
            to_cnt  <= '0;
            gap_cnt <= '0;
            channel <= '0;
            address <= '0;
            data    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (req_valid) begin
                    cap_ch  <= req_channel;
                    cap_rgb <= req_rgb;
                    idx     <= '0;
                end
                S_DRIVE: begin
                    to_cnt <= to_cnt + 10'd1;
                    if (ack && !nib_last) idx <= idx + 3'd1;
                end
                S_GAP:   gap_cnt <= gap_cnt + 4'd1;
                default: ;
            endcase
            if (drive_entry) begin
                to_cnt  <= '0;
                channel <= src_ch;
                address <= {1'b0, src_idx};
                data    <= nib_sel(src_rgb, src_idx);
            end
            if (gap_entry) gap_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_color_write_sequencer.sv
// Random-stimulus scoreboard bench: a request-level model predicts every nibble
// write, its duration and spacing, and the closing done/err pulse.
module tb_color_write_sequencer;

    localparam int TO  = 8;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_channel;
    logic [23:0] req_rgb;
    logic [1:0]  channel;
    logic [3:0]  address;
    logic [3:0]  data;
    logic        valid;
    logic        ack;
    logic        busy;
    logic        done;
    logic        err;

    color_write_sequencer #(.ACK_TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_channel(req_channel), .req_rgb(req_rgb), .channel(channel),
        .address(address), .data(data), .valid(valid), .ack(ack),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // kind: 0 = nibble write, 1 = done pulse, 2 = err pulse
    typedef struct {
        int kind;
        int ch;
        int addr;
        int data;
        int dur;
        int lead;
    } ev_t;

    ev_t exp_q[$];
    int  ack_q[$];
    int  n_chk = 0;
    int  n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: nibble k is rgb bits [4k+3:4k]; d[k]==0 means no ack ever comes.
    function automatic void model(input int ch, input int rgb, input int d[6]);
        for (int k = 0; k < 6; k++) begin
            ev_t e;
            e = '{kind: 0, ch: ch, addr: k, data: (rgb >> (4 * k)) & 15,
                  dur: 0, lead: (k == 0) ? 0 : GAP};
            if (d[k] == 0) begin
                e.dur = TO;
                exp_q.push_back(e);
                ack_q.push_back(0);
                exp_q.push_back('{kind: 2, ch: 0, addr: 0, data: 0, dur: 0, lead: 0});
                return;
            end
            e.dur = d[k];
            exp_q.push_back(e);
            ack_q.push_back(d[k]);
        end
        exp_q.push_back('{kind: 1, ch: 0, addr: 0, data: 0, dur: 0, lead: 0});
    endfunction

    task automatic send(input int ch, input int rgb, input int d[6], input bit hold);
        bit ok;
        ok = 1'b0;
        req_valid   = 1'b1;
        req_channel = 2'(ch);
        req_rgb     = 24'(rgb);
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got no req_ready expected accept within 3000 cycles");
            req_valid = 1'b0;
            return;
        end
        model(ch, rgb, d);
        @(posedge clk);
        #1;
        if (!hold) begin
            req_valid   = 1'b0;
            req_channel = 2'($urandom);
            req_rgb     = 24'($urandom);
        end
    endtask

    // Ack responder: acks on the d-th cycle of each write, random spurious acks when idle.
    initial begin
        int  d, n;
        bit  act;
        ack = 1'b0;
        act = 1'b0;
        d   = 1;
        n   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) begin
                if (!act) begin
                    d   = (ack_q.size() > 0) ? ack_q.pop_front() : 1;
                    n   = 1;
                    act = 1'b1;
                end else begin
                    n++;
                end
                ack = (d != 0) && (n == d);
            end else begin
                act = 1'b0;
                ack = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor
    initial begin
        bit  was_valid, in_write, prev_rst;
        int  dur, idle_run;
        ev_t cur, e;
        was_valid = 0; in_write = 0; prev_rst = 0; dur = 0; idle_run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_write = 0; was_valid = 0; idle_run = 0; prev_rst = 1;
            end else begin
                if (prev_rst)
                    chk("reset_state", {valid, busy, req_ready, done, err, channel, address, data},
                        {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0});
                prev_rst = 0;
                chk("busy_vs_ready", busy, !req_ready);
                if (done && err) chk("done_err_exclusive", 1, 0);
                if (was_valid && !valid && in_write) begin
                    chk("write_cycles", dur, cur.dur);
                    in_write = 0;
                end
                if (valid && !was_valid) begin
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_write: got addr %0d expected none", address);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("event_kind_write", 0, cur.kind);
                        chk("write_channel", channel, cur.ch);
                        chk("write_address", address, cur.addr);
                        chk("write_data", data, cur.data);
                        chk("write_lead", idle_run, cur.lead);
                        in_write = 1;
                        dur = 1;
                    end
                end else if (valid && in_write) begin
                    dur++;
                    chk("write_stable", {channel, address, data},
                        {cur.ch[1:0], cur.addr[3:0], cur.data[3:0]});
                end
                if (done || err) begin
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none", done, err);
                    end else begin
                        e = exp_q.pop_front();
                        chk("end_pulse_kind", done ? 1 : 2, e.kind);
                        chk("end_pulse_lead", idle_run, e.lead);
                    end
                end
                if (valid || (req_valid && req_ready)) idle_run = 0;
                else idle_run++;
                was_valid = valid;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d[6];
        int r;
        bit ok;
        rst = 1'b1; req_valid = 1'b0; req_channel = '0; req_rgb = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        d = '{2, 2, 2, 2, 2, 2};
        send(2, 24'hA1B2C3, d, 1'b0);
        d = '{1, 1, 1, 1, 1, 1};
        send(1, 24'h123456, d, 1'b1);
        d = '{0, 1, 1, 1, 1, 1};
        send(3, 24'hFEDCBA, d, 1'b0);
        d = '{TO, 1, TO, 1, 1, TO};
        send(0, 24'h0F0F0F, d, 1'b0);

        // Reset in the middle of the address-3 write, with a request offered at the same time.
        d = '{1, 1, 1, 6, 1, 1};
        send(2, 24'h987654, d, 1'b0);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (valid && address == 4'd3) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach_addr3", ok, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 1'b1;
        exp_q.delete();
        ack_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        d = '{1, 3, 1, 2, 1, 1};
        send(1, 24'h5A5A5A, d, 1'b0);

        for (int i = 0; i < 30; i++) begin
            for (int k = 0; k < 6; k++) begin
                r = $urandom_range(0, 99);
                d[k] = (r < 4) ? 0 : (r < 12) ? TO : $urandom_range(1, 4);
            end
            send($urandom_range(0, 3), $urandom, d, (i != 29) && ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
        end

        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("final_idle", {busy, req_ready}, 2'b01);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/color_write_sequencer.md
COLOR_WRITE_SEQUENCER -- requirements
Module: color_write_sequencer

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255, max cycles waiting for ack per nibble before abort (1..1023).
REQ-002 Parameter GAP_CYCLES, default 1, idle cycles with valid low between nibble writes (1..15).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  requester offers a 24-bit colour write.
REQ-006 req_ready  output  1  sequencer accepts request (high only in IDLE).
REQ-007 req_channel  input  2  target colour channel 0..3.
REQ-008 req_rgb  input  24  colour value, {R[23:16],G[15:8],B[7:0]}.
REQ-009 channel  output  2  channel driven to colour register file.
REQ-010 address  output  4  nibble index 0..5 driven to colour register file.
REQ-011 data  output  4  nibble value driven to colour register file.
REQ-012 valid  output  1  write strobe to colour register file.
REQ-013 ack  input  1  write acknowledge from colour register file.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse after sixth nibble acked.
REQ-016 err  output  1  one-cycle pulse on ack timeout abort.

Function
REQ-017 States: IDLE, DRIVE, GAP, FINISH, ABORT; encoding free.
REQ-018 IDLE: req_ready=1; on req_valid&req_ready, capture req_channel and req_rgb into internal registers, nibble index=0, go DRIVE next cycle.
REQ-019 Request inputs are ignored outside IDLE; captured copies stay constant for the whole transaction.
REQ-020 DRIVE: valid=1, address=nibble index, data=captured_rgb[4*index+3 : 4*index], channel=captured channel; all four held stable until ack.
REQ-021 Nibble order: index 0 (rgb[3:0]) first, index 5 (rgb[23:20]) last.
REQ-022 Ack sampled high in DRIVE: valid deasserts next cycle; if index<5, index increments and go GAP; if index=5, go FINISH.
REQ-023 Ack high outside DRIVE is ignored and does not advance the sequence.
REQ-024 GAP: valid=0 for exactly GAP_CYCLES cycles, then DRIVE with next index.
REQ-025 Timeout counter clears on entry to DRIVE, increments each DRIVE cycle without ack; at count = ACK_TIMEOUT with no ack, go ABORT.
REQ-026 Ack in the same cycle the counter reaches ACK_TIMEOUT counts as success (ack wins).
REQ-027 FINISH: done=1 for one cycle, valid=0, then IDLE.
REQ-028 ABORT: err=1 for one cycle, valid=0, remaining nibbles not written, then IDLE.
REQ-029 Latency, GAP_CYCLES=1, ack returned in first DRIVE cycle: accept at cycle 0, first valid cycle 1, done pulse cycle 12, req_ready high again cycle 13.
REQ-030 done and err never assert in the same cycle; busy=0 exactly when req_ready=1.
REQ-031 channel/address/data hold last driven values when valid=0; consumers ignore them then.

Reset
REQ-032 rst sampled high: state IDLE, valid=0, done=0, err=0, busy=0, req_ready=1, channel=0, address=0, data=0, counters and captured registers zeroed.
REQ-033 rst mid-transaction aborts immediately with no done/err pulse; valid low from the cycle after rst is sampled.
REQ-034 rst overrides every other input, including req_valid and ack in the same cycle.

Verification
REQ-035 Ack one cycle after each valid rise, request ch=2, rgb=0xA1B2C3 -> writes (addr,data)=(0,3),(1,C),(2,2),(3,B),(4,1),(5,A) on channel 2, one done pulse, no err.
REQ-036 ack tied low, ACK_TIMEOUT=8 -> valid high for exactly 8 cycles at address 0, err pulse, return to IDLE, no done.
REQ-037 req_valid held high with new values during transaction -> second request accepted only after done, first transaction data unchanged.
REQ-038 Spurious ack pulses during GAP and IDLE -> no address advance, exactly six writes total.
REQ-039 rst asserted while at address 3 -> valid low next cycle, busy=0, req_ready=1, no done/err; fresh request then starts at address 0.
REQ-040 Ack arriving on the exact timeout cycle -> treated as success, sequence continues to next nibble, no err.
